// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between register read, the ALU issue stage
// and the execute stage.
interface alu_issue_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [4:0]       rd;
    logic             rd_we;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;

    // The issue stage itself.
    modport slave (
        input  in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, rd, rd_we,
               illegal, issued_cnt
    );

    // Whatever drives the stage (upstream and execute side together).
    modport master (
        output in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, rd, rd_we,
               illegal, issued_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV64I ID/EX issue stage: decodes integer ALU instructions into an
// alu_op and two 64-bit operands held in a single-entry output register.
module alu_issue_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input logic       clk,
    input logic       rst,
    alu_issue_if.slave bus
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_ADDW = 4'hA,
        ALU_SUBW = 4'hB,
        ALU_SLLW = 4'hC,
        ALU_SRLW = 4'hD,
        ALU_SRAW = 4'hE,
        ALU_NOP  = 4'hF
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_ALT  = 6'b010000;

    typedef struct packed {
        alu_op_e         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            ill;
    } req_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [5:0]      f6;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt6;
    logic [XLEN-1:0] shamt5;

    req_t            dec;
    logic            legal;

    req_t            req_q;
    logic            valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic            in_ready;
    logic            load;
    logic            fire_out;

    assign opcode = bus.inst[6:0];
    assign f3     = bus.inst[14:12];
    assign f7     = bus.inst[31:25];
    assign f6     = bus.inst[31:26];

    assign imm_i  = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
    assign imm_u  = {{(XLEN-32){bus.inst[31]}}, bus.inst[31:12], 12'h000};
    assign shamt6 = {{(XLEN-6){1'b0}}, bus.inst[25:20]};
    assign shamt5 = {{(XLEN-5){1'b0}}, bus.inst[24:20]};

    // Decode the incoming instruction into ALU operation and operands.
    always_comb begin
        dec       = '0;
        dec.op    = ALU_NOP;
        dec.rd    = bus.inst[11:7];
        legal     = 1'b1;

        case (opcode)
            OPC_OP: begin
                dec.a = bus.rs1_data;
                dec.b = bus.rs2_data;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  dec.op = ALU_ADD;
                        3'b001:  dec.op = ALU_SLL;
                        3'b010:  dec.op = ALU_SLT;
                        3'b011:  dec.op = ALU_SLTU;
                        3'b100:  dec.op = ALU_XOR;
                        3'b101:  dec.op = ALU_SRL;
                        3'b110:  dec.op = ALU_OR;
                        default: dec.op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end

            OPC_OP_IMM: begin
                dec.a = bus.rs1_data;
                dec.b = imm_i;
                case (f3)
                    3'b000: dec.op = ALU_ADD;
                    3'b010: dec.op = ALU_SLT;
                    // SLTIU still sees the sign-extended immediate.
                    3'b011: dec.op = ALU_SLTU;
                    3'b100: dec.op = ALU_XOR;
                    3'b110: dec.op = ALU_OR;
                    3'b111: dec.op = ALU_AND;
                    3'b001: begin
                        dec.b = shamt6;
                        if (f6 == F6_BASE) dec.op = ALU_SLL;
                        else               legal  = 1'b0;
                    end
                    default: begin
                        dec.b = shamt6;
                        if (f6 == F6_BASE)     dec.op = ALU_SRL;
                        else if (f6 == F6_ALT) dec.op = ALU_SRA;
                        else                   legal  = 1'b0;
                    end
                endcase
            end

            OPC_OP_32: begin
                dec.a = bus.rs1_data;
                dec.b = bus.rs2_data;
                if (f7 == F7_BASE && f3 == 3'b000) begin
                    dec.op = ALU_ADDW;
                end else if (f7 == F7_BASE && f3 == 3'b001) begin
                    dec.op = ALU_SLLW;
                end else if (f7 == F7_BASE && f3 == 3'b101) begin
                    dec.op = ALU_SRLW;
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.op = ALU_SUBW;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.op = ALU_SRAW;
                end else begin
                    legal = 1'b0;
                end
            end

            OPC_IMM_32: begin
                dec.a = bus.rs1_data;
                dec.b = shamt5;
                // Word shifts only take a 5-bit shamt, so inst[25] must be 0,
                // which the full funct7 compare enforces.
                if (f3 == 3'b000) begin
                    dec.op = ALU_ADDW;
                    dec.b  = imm_i;
                end else if (f3 == 3'b001 && f7 == F7_BASE) begin
                    dec.op = ALU_SLLW;
                end else if (f3 == 3'b101 && f7 == F7_BASE) begin
                    dec.op = ALU_SRLW;
                end else if (f3 == 3'b101 && f7 == F7_ALT) begin
                    dec.op = ALU_SRAW;
                end else begin
                    legal = 1'b0;
                end
            end

            OPC_LUI: begin
                dec.op = ALU_ADD;
                dec.a  = '0;
                dec.b  = imm_u;
            end

            OPC_AUIPC: begin
                dec.op = ALU_ADD;
                dec.a  = bus.pc;
                dec.b  = imm_u;
            end

            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.op = ALU_NOP;
            dec.a  = '0;
            dec.b  = '0;
        end

        dec.ill   = !legal;
        dec.rd_we = legal && (dec.rd != 5'd0);
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready && !bus.flush;
    assign fire_out = valid_q && bus.out_ready;

    // Single-entry output register; flush wins over load and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            req_q   <= dec;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Count every consumed request, even in a flush cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (fire_out) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.alu_op     = req_q.op;
    assign bus.alu_a      = req_q.a;
    assign bus.alu_b      = req_q.b;
    assign bus.rd         = req_q.rd;
    assign bus.rd_we      = req_q.rd_we;
    assign bus.illegal    = req_q.ill;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus a random
// stream compared each cycle against a behavioural model.
module tb_alu_issue_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_issue_if #(.XLEN(64), .CNT_W(32)) bus ();

    alu_issue_stage #(.XLEN(64), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    // Reference decode from the instruction tables: -1 means illegal.
    function automatic exp_t ref_dec(input logic [31:0] i,
                                     input logic [63:0] pc,
                                     input logic [63:0] r1,
                                     input logic [63:0] r2);
        int          rtab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        int          op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] immi;
        logic [63:0] immu;
        logic [2:0]  f3;
        logic [6:0]  f7;
        exp_t        e;
        f3   = i[14:12];
        f7   = i[31:25];
        immi = {{52{i[31]}}, i[31:20]};
        immu = {{32{i[31]}}, i[31:12], 12'h000};
        op   = -1;
        a    = r1;
        b    = r2;
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00) op = rtab[f3];
                else if (f7 == 7'h20) op = (f3 == 0) ? 1 : (f3 == 5) ? 9 : -1;
            end
            7'h13: begin
                b = immi;
                if (f3 == 1 || f3 == 5) b = 64'(i[25:20]);
                if (f3 == 1)      op = (i[31:26] == 0) ? 7 : -1;
                else if (f3 == 5) op = (i[31:26] == 0) ? 8 :
                                       (i[31:26] == 6'h10) ? 9 : -1;
                else              op = rtab[f3];
            end
            7'h3B: begin
                if (f7 == 7'h00)
                    op = (f3 == 0) ? 10 : (f3 == 1) ? 12 : (f3 == 5) ? 13 : -1;
                else if (f7 == 7'h20)
                    op = (f3 == 0) ? 11 : (f3 == 5) ? 14 : -1;
            end
            7'h1B: begin
                b = 64'(i[24:20]);
                if (f3 == 0) begin op = 10; b = immi; end
                else if (f3 == 1 && f7 == 7'h00) op = 12;
                else if (f3 == 5 && f7 == 7'h00) op = 13;
                else if (f3 == 5 && f7 == 7'h20) op = 14;
            end
            7'h37: begin op = 0; a = 0;  b = immu; end
            7'h17: begin op = 0; a = pc; b = immu; end
            default: op = -1;
        endcase
        e.rd = i[11:7];
        if (op < 0) begin
            e.op = 4'hF; e.a = 0; e.b = 0; e.we = 0; e.ill = 1;
        end else begin
            e.op = 4'(op); e.a = a; e.b = b; e.ill = 0;
            e.we = (i[11:7] != 0);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model state.
    logic        m_valid;
    logic [31:0] m_cnt;
    exp_t        m_e;

    // Model update at each clock edge; reset acts at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            bit rdy;
            rdy = !m_valid || bus.out_ready;
            if (m_valid && bus.out_ready) m_cnt = m_cnt + 1;
            if (bus.flush) m_valid = 1'b0;
            else if (bus.in_valid && rdy) begin
                m_valid = 1'b1;
                m_e = ref_dec(bus.inst, bus.pc, bus.rs1_data, bus.rs2_data);
            end else if (bus.out_ready) m_valid = 1'b0;
        end
    end

    // Compare DUT against model mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
            chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("issued_cnt", 64'(bus.issued_cnt), 64'(m_cnt));
            if (m_valid) begin
                chk("alu_op", 64'(bus.alu_op), 64'(m_e.op));
                chk("alu_a", bus.alu_a, m_e.a);
                chk("alu_b", bus.alu_b, m_e.b);
                chk("rd", 64'(bus.rd), 64'(m_e.rd));
                chk("rd_we", 64'(bus.rd_we), 64'(m_e.we));
                chk("illegal", 64'(bus.illegal), 64'(m_e.ill));
            end
        end
    end

    task automatic drive(input logic [31:0] i, input logic [63:0] p,
                         input logic [63:0] r1, input logic [63:0] r2);
        bus.inst     = i;
        bus.pc       = p;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    task automatic send_check(input string nm, input logic [31:0] i,
                              input logic [63:0] p, input logic [63:0] r1,
                              input logic [63:0] r2, input logic [3:0] op,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [4:0] rd, input logic we,
                              input logic ill);
        @(posedge clk); #1;
        drive(i, p, r1, r2);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_op"}, 64'(bus.alu_op), 64'(op));
        chk({nm, "_a"}, bus.alu_a, a);
        chk({nm, "_b"}, bus.alu_b, b);
        chk({nm, "_rd"}, 64'(bus.rd), 64'(rd));
        chk({nm, "_we"}, 64'(bus.rd_we), 64'(we));
        chk({nm, "_ill"}, 64'(bus.illegal), 64'(ill));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [6:0]  opcs [7] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37,
                                  7'h17, 7'h00};
        int          k;
        i = $urandom;
        k = $urandom_range(0, 6);
        if (k < 6) i[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            2: i[31:25] = {6'h10, i[25]};
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        exp_t pin;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        drive(32'h0, 64'h0, 64'h0, 64'h0);

        // Pin the reference model on known encodings.
        pin = ref_dec(32'hFFF00093, 64'h0, 64'h0, 64'h0);
        chk("model_addi_b", pin.b, 64'hFFFF_FFFF_FFFF_FFFF);
        pin = ref_dec(32'h4203529B, 64'h0, 64'h9, 64'h0);
        chk("model_sraiw_op", 64'(pin.op), 64'hF);
        pin = ref_dec(32'h43F35293, 64'h0, 64'h9, 64'h0);
        chk("model_srai_b", pin.b, 64'd63);

        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
        chk("rst_alu_a", bus.alu_a, 64'd0);
        chk("rst_alu_b", bus.alu_b, 64'd0);
        chk("rst_rd", 64'(bus.rd), 64'd0);
        chk("rst_rd_we", 64'(bus.rd_we), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_cnt", 64'(bus.issued_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send_check("addi", 32'hFFF00093, 64'h0, 64'h0, 64'h0,
                   4'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b1, 1'b0);
        send_check("subw", 32'h402081BB, 64'h0, 64'd5, 64'd7,
                   4'hB, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0);
        send_check("srai", 32'h43F35293, 64'h0, 64'h8000_0000_0000_1234,
                   64'h55, 4'h9, 64'h8000_0000_0000_1234, 64'd63,
                   5'd5, 1'b1, 1'b0);
        send_check("sraiw32", 32'h4203529B, 64'h0, 64'h77, 64'h0,
                   4'hF, 64'h0, 64'h0, 5'd5, 1'b0, 1'b1);
        send_check("lui", 32'h80000137, 64'h0, 64'h1111, 64'h0,
                   4'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 5'd2, 1'b1, 1'b0);
        send_check("auipc", 32'h00001517, 64'h1000, 64'h0, 64'h0,
                   4'h0, 64'h1000, 64'h1000, 5'd10, 1'b1, 1'b0);

        // Reset while a request is stalled.
        @(posedge clk); #1;
        drive(32'hFFF00093, 64'h0, 64'h0, 64'h0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_cnt", 64'(bus.issued_cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Stall three cycles, then flush with a new instruction offered.
        @(posedge clk); #1;
        drive(32'h402081BB, 64'h0, 64'd5, 64'd7);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        drive(32'hFFF00093, 64'h0, 64'h0, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_op", 64'(bus.alu_op), 64'hB);
            chk("stall_a", bus.alu_a, 64'd5);
            chk("stall_b", bus.alu_b, 64'd7);
            if (c < 2) @(posedge clk);
        end
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_cnt", 64'(bus.issued_cnt), 64'd0);

        // Four back-to-back requests.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive(32'h00000013 | (32'(k + 1) << 7), 64'h0, 64'(k), 64'h0);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("stream_cnt", 64'(bus.issued_cnt), 64'd4);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            drive(rand_inst(), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom});
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
